regb_fifo_ctrl: RTL

Push arbiter and occupancy controller for the register-based FIFO chain built from `fifo_unit` cells. It shares the single FIFO write port between N requesters by round-robin and drives the chain's `shift_in`/`shift_out` strobes from the requester grants and the consumer's `pop`. It also tracks occupancy and provides the `empty`, `full` and `almost_full` flags for the whole chain. The block sits between the requesters, the FIFO chain and the consumer; the FIFO data path itself stays in the `fifo_unit` cells.

---
 rtl/regb_fifo_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/regb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// regb_fifo_ctrl
//
// Push arbiter and occupancy controller for a register-based FIFO chain made
// of fifo_unit cells. N requesters share the chain's single write port by
// round-robin. This block drives the chain's shift_in/shift_out strobes and
// tracks the occupancy of the whole chain. The data path stays in the cells;
// this block only steers the granted requester's word onto si.
//
// Parameters
//   WIDTH    : data width per entry (must match the chain)
//   DEPTH    : number of fifo_unit cells in the chain, >= 2
//   N        : number of push requesters, >= 2
//   AF_LEVEL : almost_full threshold, 1..DEPTH
//   CW       : occupancy counter width, $clog2(DEPTH+1)
//
// Ports
//   clk         in   1        : single clock, rising-edge active
//   res         in   1        : synchronous active-high reset
//   req         in   N        : per-requester push request
//   req_data    in   N*WIDTH  : requester i data at [i*WIDTH +: WIDTH]
//   gnt         out  N        : one-hot or zero; word i is written at this edge
//   pop         in   1        : consumer pop request
//   shift_in    out  1        : write strobe to the chain
//   si          out  WIDTH    : granted requester's data, zero when no grant
//   shift_out   out  1        : pop strobe to the chain
//   count       out  CW       : occupancy
//   empty       out  1        : occupancy == 0
//   full        out  1        : occupancy == DEPTH
//   almost_full out  1        : occupancy >= AF_LEVEL
//
// gnt, shift_in, si and shift_out are combinational from the inputs and the
// registered state, so a push is written at the same edge it is granted.
// count and the flags are registers and change one cycle after the edge.
// -----------------------------------------------------------------------------
module regb_fifo_ctrl #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 8,
  parameter int N        = 4,
  parameter int AF_LEVEL = 6,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   req_data,
  output logic [N-1:0]         gnt,
  input  logic                 pop,
  output logic                 shift_in,
  output logic [WIDTH-1:0]     si,
  output logic                 shift_out,
  output logic [CW-1:0]        count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full
);

  // Pointer width; the candidate index carries one extra bit so that
  // ptr + offset can be wrapped modulo N without overflowing.
  localparam int PW = $clog2(N);

  localparam logic [PW:0]    N_W      = (PW + 1)'(N);
  localparam logic [PW-1:0]  LAST_IDX = PW'(N - 1);
  localparam logic [PW-1:0]  ONE_P    = PW'(1);
  localparam logic [CW-1:0]  ONE_C    = CW'(1);
  localparam logic [CW-1:0]  DEPTH_W  = CW'(DEPTH);
  localparam logic [CW-1:0]  AF_W     = CW'(AF_LEVEL);

  // Registered state and its next-state values.
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic [PW-1:0]  ptr_q;
  logic [PW-1:0]  ptr_d;
  logic           empty_q;
  logic           full_q;
  logic           af_q;

  // Arbitration intermediates.
  logic [PW:0]    cand_s;
  logic [PW-1:0]  win_idx_s;
  logic           win_found_s;
  logic           push_ok_s;
  logic           shift_in_s;
  logic           shift_out_s;
  logic [N-1:0]   gnt_s;
  logic [WIDTH-1:0] si_s;

  // Round-robin search: scan req starting at ptr, ascending, wrapping at N.
  always_comb begin
    cand_s      = {(PW + 1){1'b0}};
    win_idx_s   = {PW{1'b0}};
    win_found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = {1'b0, ptr_q} + (PW + 1)'(k);
      if (cand_s >= N_W) begin
        cand_s = cand_s - N_W;
      end else begin
        cand_s = cand_s;
      end
      if (!win_found_s && req[cand_s[PW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand_s[PW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Strobes and grant. A pop on an empty chain is dropped, and a push into a
  // full chain is only allowed when the same edge also pops. Reset forces
  // every strobe low so pending requests are dropped.
  always_comb begin
    shift_out_s = pop & ~empty_q & ~res;
    push_ok_s   = (~full_q | shift_out_s) & ~res;
    shift_in_s  = push_ok_s & win_found_s;
    gnt_s       = {N{1'b0}};
    si_s        = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (shift_in_s && (win_idx_s == PW'(i))) begin
        gnt_s[i] = 1'b1;
        si_s     = req_data[i*WIDTH +: WIDTH];
      end else begin
        gnt_s[i] = 1'b0;
      end
    end
  end

  // Next-state: occupancy follows push minus pop; the pointer moves just past
  // the winner only when a word is actually written.
  always_comb begin
    case ({shift_in_s, shift_out_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    if (shift_in_s) begin
      if (win_idx_s == LAST_IDX) begin
        ptr_d = {PW{1'b0}};
      end else begin
        ptr_d = win_idx_s + ONE_P;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // State register. The flags are registered from count_d so that they always
  // equal a decode of the count register and never see this cycle's inputs.
  always_ff @(posedge clk) begin
    if (res) begin
      count_q <= {CW{1'b0}};
      ptr_q   <= {PW{1'b0}};
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ptr_q   <= ptr_d;
      empty_q <= (count_d == {CW{1'b0}});
      full_q  <= (count_d == DEPTH_W);
      af_q    <= (count_d >= AF_W);
    end
  end

  assign gnt         = gnt_s;
  assign shift_in    = shift_in_s;
  assign si          = si_s;
  assign shift_out   = shift_out_s;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;

endmodule
